// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer over one shared memory port,
// with cycle and retired-instruction counters. Optional `ILLEGAL_TRAP_EN halts on unknown opcodes.
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       Op,
   input  logic [5:0]       Funct,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             MemRead,
   output logic             MemWrEn,
   output logic             RegWrEn,
   output logic             IorD,
   output logic             instr_done,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt,
   output logic             illegal
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd7
   } state_t;

   state_t cur_state, nxt_state;

   logic is_ld, is_st, is_br, is_j, is_jal, is_ialu, is_rt, is_jr;
   logic to_pc, to_mem, to_wb;
`ifdef ILLEGAL_TRAP_EN
   logic trap;
   logic illegal_q;
`endif

   always_comb begin
      is_ld   = 1'b0;
      is_st   = 1'b0;
      is_br   = 1'b0;
      is_j    = 1'b0;
      is_jal  = 1'b0;
      is_ialu = 1'b0;
      is_rt   = 1'b0;
      case (Op)
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: is_ld   = 1'b1;
         6'h28, 6'h29, 6'h2B:               is_st   = 1'b1;
         6'h04, 6'h05:                      is_br   = 1'b1;
         6'h02:                             is_j    = 1'b1;
         6'h03:                             is_jal  = 1'b1;
         6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: is_ialu = 1'b1;
         6'h00:                             is_rt   = 1'b1;
         default: ;
      endcase
   end

   assign is_jr  = is_rt && (Funct == 6'h08);
   assign to_pc  = is_br || is_j || is_jr;
   assign to_mem = is_ld || is_st;
   assign to_wb  = (is_rt && !is_jr) || is_ialu || is_jal;

   // PCWrite and instr_done always coincide: the PC advances exactly when an instruction retires.
   always_comb begin
      nxt_state  = cur_state;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrEn    = 1'b0;
      RegWrEn    = 1'b0;
      IorD       = 1'b0;
      instr_done = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      trap       = 1'b0;
`endif
      if (!rst) begin
         case (cur_state)
            FETCH: begin
               MemRead = 1'b1;
               if (mem_ready) begin
                  IRWrite   = 1'b1;
                  nxt_state = DECODE;
               end
            end
            DECODE: nxt_state = EXEC;
            EXEC: begin
               if (to_pc) begin
                  PCWrite    = 1'b1;
                  instr_done = 1'b1;
                  nxt_state  = FETCH;
               end else if (to_mem) begin
                  nxt_state = MEM;
               end else if (to_wb) begin
                  nxt_state = WB;
               end else begin
`ifdef ILLEGAL_TRAP_EN
                  trap      = 1'b1;
                  nxt_state = HALT;
`else
                  PCWrite    = 1'b1;
                  instr_done = 1'b1;
                  nxt_state  = FETCH;
`endif
               end
            end
            MEM: begin
               IorD    = 1'b1;
               MemRead = is_ld;
               MemWrEn = !is_ld;
               if (mem_ready) begin
                  if (is_ld) begin
                     nxt_state = WB;
                  end else begin
                     PCWrite    = 1'b1;
                     instr_done = 1'b1;
                     nxt_state  = FETCH;
                  end
               end
            end
            WB: begin
               RegWrEn    = 1'b1;
               PCWrite    = 1'b1;
               instr_done = 1'b1;
               nxt_state  = FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            HALT: nxt_state = HALT;
`endif
            default: nxt_state = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cur_state <= FETCH;
      else     cur_state <= nxt_state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         if (instr_done) instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

`ifdef ILLEGAL_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       illegal_q <= 1'b0;
      else if (trap) illegal_q <= 1'b1;
   end
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   assign state = cur_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: a per-cycle trace is generated from the instruction-class
// rules, replayed as stimulus by a driver and compared by an independent monitor.
module tb_mc_ctrl;

   logic        clk;
   logic        rst;
   logic [5:0]  Op;
   logic [5:0]  Funct;
   logic        mem_ready;
   logic        PCWrite, IRWrite, MemRead, MemWrEn, RegWrEn, IorD, instr_done;
   logic [2:0]  state;
   logic [31:0] cycle_cnt, instr_cnt;
   logic        illegal;

   mc_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrEn(MemWrEn),
      .RegWrEn(RegWrEn), .IorD(IorD), .instr_done(instr_done), .state(state),
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [6:0] S_PCW  = 7'b1000000;
   localparam logic [6:0] S_IRW  = 7'b0100000;
   localparam logic [6:0] S_MRD  = 7'b0010000;
   localparam logic [6:0] S_MWE  = 7'b0001000;
   localparam logic [6:0] S_RWE  = 7'b0000100;
   localparam logic [6:0] S_IORD = 7'b0000010;
   localparam logic [6:0] S_DONE = 7'b0000001;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        mr;
      logic [6:0]  stb;
      logic [2:0]  st;
      logic [31:0] cyc;
      logic [31:0] icnt;
      logic        ill;
   } ent_t;

   ent_t stim_q[$];
   ent_t exp_q[$];

   logic [5:0]  cur_op, cur_funct;
   logic [31:0] m_cyc, m_icnt;
   logic        m_ill;
   int          checks, errors;

   function automatic logic rbit();
      return ($urandom_range(0, 1) != 0);
   endfunction

   // One cycle of the reference trace; counters are the values visible during that cycle.
   task automatic push(input logic r, input logic mr, input logic [2:0] st, input logic [6:0] stb);
      ent_t e;
      if (r) begin
         m_cyc = 0; m_icnt = 0; m_ill = 1'b0;
      end
      e.rst = r; e.op = cur_op; e.funct = cur_funct; e.mr = mr;
      e.stb = r ? 7'd0 : stb;
      e.st  = r ? 3'd0 : st;
      e.cyc = m_cyc; e.icnt = m_icnt; e.ill = m_ill;
      stim_q.push_back(e);
      exp_q.push_back(e);
      if (!r) begin
         m_cyc = m_cyc + 1;
         if (stb[0]) m_icnt = m_icnt + 1;
      end
   endtask

   task automatic do_instr(input logic [5:0] op, input logic [5:0] funct, input int fw, input int mw);
      logic ld, stq, pc, wb;
      cur_op = op; cur_funct = funct;
      ld  = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
      stq = op inside {6'h28, 6'h29, 6'h2B};
      pc  = (op inside {6'h04, 6'h05, 6'h02}) || (op == 6'h00 && funct == 6'h08);
      wb  = (op == 6'h00 && funct != 6'h08) || (op inside {6'h03, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F});
      for (int i = 0; i < fw; i++) push(1'b0, 1'b0, 3'd0, S_MRD);
      push(1'b0, 1'b1, 3'd0, S_MRD | S_IRW);
      push(1'b0, rbit(), 3'd1, 7'd0);
      if (pc) begin
         push(1'b0, rbit(), 3'd2, S_PCW | S_DONE);
      end else if (ld || stq) begin
         push(1'b0, rbit(), 3'd2, 7'd0);
         for (int i = 0; i < mw; i++) push(1'b0, 1'b0, 3'd3, S_IORD | (ld ? S_MRD : S_MWE));
         push(1'b0, 1'b1, 3'd3, S_IORD | (ld ? S_MRD : (S_MWE | S_PCW | S_DONE)));
         if (ld) push(1'b0, rbit(), 3'd4, S_RWE | S_PCW | S_DONE);
      end else if (wb) begin
         push(1'b0, rbit(), 3'd2, 7'd0);
         push(1'b0, rbit(), 3'd4, S_RWE | S_PCW | S_DONE);
      end else begin
`ifdef ILLEGAL_TRAP_EN
         push(1'b0, rbit(), 3'd2, 7'd0);
         m_ill = 1'b1;
`else
         push(1'b0, rbit(), 3'd2, S_PCW | S_DONE);
`endif
      end
   endtask

   // Trace generation: directed cases first, then a randomized instruction stream.
   initial begin
      logic [5:0] tab[$];
      logic [5:0] op, fn;
      m_cyc = 0; m_icnt = 0; m_ill = 1'b0;
      cur_op = 6'h00; cur_funct = 6'h00;
      tab = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h04, 6'h05,
              6'h02, 6'h03, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h00, 6'h00, 6'h00};
`ifndef ILLEGAL_TRAP_EN
      tab.push_back(6'h3F);
      tab.push_back(6'h01);
      tab.push_back(6'h3E);
`endif
      for (int i = 0; i < 3; i++) push(1'b1, 1'b0, 3'd0, 7'd0);
      do_instr(6'h00, 6'h21, 0, 0);
      do_instr(6'h23, 6'h00, 0, 2);
      do_instr(6'h2B, 6'h00, 0, 0);
      do_instr(6'h04, 6'h00, 0, 0);
      do_instr(6'h00, 6'h08, 0, 0);
      do_instr(6'h00, 6'h09, 1, 0);
      // sw interrupted by reset while its write is waiting on mem_ready
      cur_op = 6'h2B; cur_funct = 6'h00;
      push(1'b0, 1'b1, 3'd0, S_MRD | S_IRW);
      push(1'b0, 1'b0, 3'd1, 7'd0);
      push(1'b0, 1'b0, 3'd2, 7'd0);
      push(1'b0, 1'b0, 3'd3, S_IORD | S_MWE);
      push(1'b0, 1'b0, 3'd3, S_IORD | S_MWE);
      push(1'b1, 1'b0, 3'd0, 7'd0);
      push(1'b1, 1'b1, 3'd0, 7'd0);
      do_instr(6'h00, 6'h21, 0, 0);
      for (int n = 0; n < 300; n++) begin
         op = tab[$urandom_range(0, tab.size() - 1)];
         fn = 6'($urandom_range(0, 63));
         if (op == 6'h00 && $urandom_range(0, 2) == 0) fn = ($urandom_range(0, 1) != 0) ? 6'h08 : 6'h09;
         do_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      do_instr(6'h3F, 6'h00, 0, 0);
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 6; i++) push(1'b0, rbit(), 3'd7, 7'd0);
      push(1'b1, 1'b0, 3'd0, 7'd0);
      do_instr(6'h00, 6'h21, 0, 0);
`endif
      push(1'b0, 1'b0, 3'd0, S_MRD);
   end

   // Driver: applies one trace cycle per falling edge.
   initial begin
      ent_t e;
      rst = 1'b1; Op = 6'h00; Funct = 6'h00; mem_ready = 1'b0;
      #1;
      while (stim_q.size() > 0) begin
         @(negedge clk);
         e = stim_q.pop_front();
         rst = e.rst; Op = e.op; Funct = e.funct; mem_ready = e.mr;
      end
   end

   task automatic chk(input string name, input int cyc_idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at trace cycle %0d: got %0h expected %0h", name, cyc_idx, act, exp);
      end
   endtask

   // Monitor: samples outputs shortly after the inputs settle and pops the matching expectation.
   initial begin
      ent_t e;
      int idx;
      checks = 0; errors = 0; idx = 0;
      #1;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         #1;
         e = exp_q.pop_front();
         chk("strobes", idx, 32'({PCWrite, IRWrite, MemRead, MemWrEn, RegWrEn, IorD, instr_done}), 32'(e.stb));
         chk("state", idx, 32'(state), 32'(e.st));
         chk("cycle_cnt", idx, cycle_cnt, e.cyc);
         chk("instr_cnt", idx, instr_cnt, e.icnt);
         chk("illegal", idx, 32'(illegal), 32'(e.ill));
         idx++;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no end of trace expected completion");
      $fatal(1);
   end

endmodule
